// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary wrap-bit pointers, registered status flags,
// occupancy count and sticky overflow/underflow for an external dual-port RAM.
module sync_fifo_ctrl #(
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic                rinc,
    input  logic                clr_err,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                wclken,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [ADDRSIZE:0] AFULL_V   = AFULL_TH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AEMPTY_V  = AEMPTY_TH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] FULL_DIFF = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic              AFULL_RST = (AFULL_TH == 0);

    logic [ADDRSIZE:0] wptr, rptr;
    logic [ADDRSIZE:0] wptr_n, rptr_n, count_n;
    logic              push, pop;

    // Acceptance uses the flags registered at this edge, so a push into a full
    // FIFO is rejected even when a pop is accepted in the same cycle.
    always_comb begin
        push    = winc & ~wfull;
        pop     = rinc & ~rempty;
        wptr_n  = wptr + (ADDRSIZE+1)'(push);
        rptr_n  = rptr + (ADDRSIZE+1)'(pop);
        count_n = wptr_n - rptr_n;
    end

    assign waddr  = wptr[ADDRSIZE-1:0];
    assign raddr  = rptr[ADDRSIZE-1:0];
    // Gated by reset so the RAM is never written while the controller is held.
    assign wclken = winc & ~wfull & wrst_n;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= AFULL_RST;
            ralmost_empty <= 1'b1;
        end else begin
            wptr          <= wptr_n;
            rptr          <= rptr_n;
            count         <= count_n;
            wfull         <= ((wptr_n ^ rptr_n) == FULL_DIFF);
            rempty        <= (wptr_n == rptr_n);
            walmost_full  <= (count_n >= AFULL_V);
            ralmost_empty <= (count_n <= AEMPTY_V);
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc & wfull)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (rinc & rempty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a behavioural RAM plus a queue-based FIFO model
// drive directed and randomized push/pop traffic.
module tb_sync_fifo_ctrl;

    localparam int ADDRSIZE  = 4;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 14;
    localparam int AEMPTY_TH = 2;

    logic                wclk = 1'b0;
    logic                wrst_n = 1'b0;
    logic                winc = 1'b0;
    logic                rinc = 1'b0;
    logic                clr_err = 1'b0;
    logic [7:0]          wdata = 8'h00;
    logic [ADDRSIZE-1:0] waddr, raddr;
    logic                wclken, wfull, rempty, walmost_full, ralmost_empty;
    logic [ADDRSIZE:0]   count;
    logic                overflow, underflow;

    sync_fifo_ctrl #(.ADDRSIZE(ADDRSIZE), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rinc(rinc), .clr_err(clr_err),
        .waddr(waddr), .raddr(raddr), .wclken(wclken), .wfull(wfull), .rempty(rempty),
        .walmost_full(walmost_full), .ralmost_empty(ralmost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 wclk = ~wclk;

    // Behavioural fifomem: synchronous write, asynchronous read.
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata;
    assign rdata = mem[raddr];
    always @(posedge wclk) if (wclken) mem[waddr] <= wdata;

    // Reference model state
    logic [7:0] q[$];
    int         wr_total = 0;
    int         rd_total = 0;
    bit         m_ov = 0;
    bit         m_un = 0;

    int         n_cmp = 0;
    int         n_fail = 0;

    logic       popped;
    logic [7:0] pop_got, pop_exp;
    logic       got_wclken, exp_wclken;

    task automatic model_reset();
        q.delete();
        wr_total = 0;
        rd_total = 0;
        m_ov = 0;
        m_un = 0;
    endtask

    // One clock of traffic; samples rdata/wclken before the edge and advances the model.
    task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit full, empty;
        @(negedge wclk);
        winc = w; rinc = r; clr_err = c; wdata = d;
        #1;
        full       = (q.size() == DEPTH);
        empty      = (q.size() == 0);
        got_wclken = wclken;
        exp_wclken = w && !full;
        popped     = r && !empty;
        pop_got    = rdata;
        pop_exp    = popped ? q[0] : 8'h00;
        @(posedge wclk);
        if (w && !full) begin q.push_back(d); wr_total++; end
        if (popped) begin void'(q.pop_front()); rd_total++; end
        if (w && full) m_ov = 1; else if (c) m_ov = 0;
        if (r && empty) m_un = 1; else if (c) m_un = 0;
        #1;
        winc = 0; rinc = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        winc = 1'b1;
        #12;
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (rempty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rempty: got %b expected 1", rempty); end
        n_cmp++; if (wfull !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wfull: got %b expected 0", wfull); end
        n_cmp++; if (ralmost_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_aempty: got %b expected 1", ralmost_empty); end
        n_cmp++; if (walmost_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_afull: got %b expected 0", walmost_full); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_err: got %b%b expected 00", overflow, underflow); end
        n_cmp++; if ({waddr, raddr} !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_addr: got %h/%h expected 0/0", waddr, raddr); end
        n_cmp++; if (wclken !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wclken: got %b expected 0", wclken); end
        winc = 1'b0;
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0, 8'(i));
            n_cmp++; if (count !== 5'(i + 1)) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, i + 1); end
            n_cmp++; if (walmost_full !== (i + 1 >= AFULL_TH)) begin n_fail++; $display("[TB] FAIL fill_afull: got %b after push %0d", walmost_full, i + 1); end
        end
        n_cmp++; if (wfull !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_wfull: got %b expected 1", wfull); end
        cycle(1, 0, 0, 8'hAA);
        n_cmp++; if (got_wclken !== 1'b0) begin n_fail++; $display("[TB] FAIL over_wclken: got %b expected 0", got_wclken); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL over_flag: got %b expected 1", overflow); end
        n_cmp++; if (mem[0] !== 8'h00) begin n_fail++; $display("[TB] FAIL over_mem0: got %h expected 00", mem[0]); end
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("[TB] FAIL over_count: got %0d expected 16", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, 8'h00);
            n_cmp++; if (pop_got !== 8'(i)) begin n_fail++; $display("[TB] FAIL drain_data: got %h expected %h", pop_got, 8'(i)); end
            n_cmp++; if (ralmost_empty !== (DEPTH - 1 - i <= AEMPTY_TH)) begin n_fail++; $display("[TB] FAIL drain_aempty: got %b at count %0d", ralmost_empty, DEPTH - 1 - i); end
        end
        n_cmp++; if (rempty !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_rempty: got %b expected 1", rempty); end
        cycle(0, 1, 0, 8'h00);
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL under_flag: got %b expected 1", underflow); end
        n_cmp++; if (raddr !== 4'(rd_total % DEPTH)) begin n_fail++; $display("[TB] FAIL under_raddr: got %h expected %h", raddr, 4'(rd_total % DEPTH)); end
        cycle(0, 0, 1, 8'h00);
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("[TB] FAIL clr_err: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 0, 8'($urandom));
            n_cmp++; if (pop_got !== pop_exp) begin n_fail++; $display("[TB] FAIL wrap_data: got %h expected %h", pop_got, pop_exp); end
            n_cmp++; if (count !== 5'd3) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 3", count); end
        end
    endtask

    task automatic test_simultaneous();
        while (q.size() > 0) cycle(0, 1, 0, 8'h00);
        cycle(1, 1, 0, 8'h5A);
        n_cmp++; if (count !== 5'd1) begin n_fail++; $display("[TB] FAIL sim_empty_count: got %0d expected 1", count); end
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_empty_under: got %b expected 1", underflow); end
        cycle(0, 0, 1, 8'h00);
        while (q.size() < DEPTH) cycle(1, 0, 0, 8'($urandom));
        cycle(1, 1, 0, 8'h77);
        n_cmp++; if (count !== 5'd15) begin n_fail++; $display("[TB] FAIL sim_full_count: got %0d expected 15", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_full_over: got %b expected 1", overflow); end
        n_cmp++; if (pop_got !== pop_exp) begin n_fail++; $display("[TB] FAIL sim_full_data: got %h expected %h", pop_got, pop_exp); end
        cycle(0, 0, 1, 8'h00);
        cycle(1, 0, 0, 8'h11);
        cycle(1, 0, 1, 8'h22);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL set_wins: got %b expected 1", overflow); end
        cycle(0, 0, 1, 8'h00);
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("[TB] FAIL sim_clr: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_random();
        int bias;
        bit w, r, c;
        int n;
        for (int blk = 0; blk < 8; blk++) begin
            bias = $urandom_range(1, 3);
            for (int k = 0; k < 50; k++) begin
                w = ($urandom_range(0, 3) < bias);
                r = ($urandom_range(0, 3) < 4 - bias);
                c = ($urandom_range(0, 15) == 0);
                cycle(w, r, c, 8'($urandom));
                n = q.size();
                n_cmp++; if (got_wclken !== exp_wclken) begin n_fail++; $display("[TB] FAIL rnd_wclken: got %b expected %b", got_wclken, exp_wclken); end
                n_cmp++; if (popped && pop_got !== pop_exp) begin n_fail++; $display("[TB] FAIL rnd_data: got %h expected %h", pop_got, pop_exp); end
                n_cmp++; if (count !== 5'(n)) begin n_fail++; $display("[TB] FAIL rnd_count: got %0d expected %0d", count, n); end
                n_cmp++; if (wfull !== (n == DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_wfull: got %b at count %0d", wfull, n); end
                n_cmp++; if (rempty !== (n == 0)) begin n_fail++; $display("[TB] FAIL rnd_rempty: got %b at count %0d", rempty, n); end
                n_cmp++; if (walmost_full !== (n >= AFULL_TH)) begin n_fail++; $display("[TB] FAIL rnd_afull: got %b at count %0d", walmost_full, n); end
                n_cmp++; if (ralmost_empty !== (n <= AEMPTY_TH)) begin n_fail++; $display("[TB] FAIL rnd_aempty: got %b at count %0d", ralmost_empty, n); end
                n_cmp++; if (overflow !== m_ov) begin n_fail++; $display("[TB] FAIL rnd_over: got %b expected %b", overflow, m_ov); end
                n_cmp++; if (underflow !== m_un) begin n_fail++; $display("[TB] FAIL rnd_under: got %b expected %b", underflow, m_un); end
                n_cmp++; if (waddr !== 4'(wr_total % DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_waddr: got %h expected %h", waddr, 4'(wr_total % DEPTH)); end
                n_cmp++; if (raddr !== 4'(rd_total % DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_raddr: got %h expected %h", raddr, 4'(rd_total % DEPTH)); end
            end
        end
    endtask

    task automatic test_async_reset();
        while (q.size() < 9) cycle(1, 0, 0, 8'($urandom));
        while (q.size() > 9) cycle(0, 1, 0, 8'h00);
        n_cmp++; if (count !== 5'd9) begin n_fail++; $display("[TB] FAIL pre_reset_count: got %0d expected 9", count); end
        @(negedge wclk);
        winc = 1'b1;
        rinc = 1'b1;
        #2;
        wrst_n = 1'b0;
        #1;
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL arst_count: got %0d expected 0", count); end
        n_cmp++; if ({rempty, wfull, ralmost_empty, walmost_full} !== 4'b1010) begin n_fail++; $display("[TB] FAIL arst_flags: got %b expected 1010", {rempty, wfull, ralmost_empty, walmost_full}); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("[TB] FAIL arst_err: got %b%b expected 00", overflow, underflow); end
        n_cmp++; if ({waddr, raddr} !== 8'h00) begin n_fail++; $display("[TB] FAIL arst_addr: got %h/%h expected 0/0", waddr, raddr); end
        n_cmp++; if (wclken !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_wclken: got %b expected 0", wclken); end
        winc = 1'b0;
        rinc = 1'b0;
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
        cycle(1, 0, 0, 8'h3C);
        cycle(0, 1, 0, 8'h00);
        n_cmp++; if (pop_got !== 8'h3C) begin n_fail++; $display("[TB] FAIL post_reset_data: got %h expected 3c", pop_got); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
